// File: rtl/pkt_mem_pkg.sv
// Shared types and constants for the packet-memory arbiter.
// Address/data defaults, requester indices and the sequencer state encoding.
package pkt_mem_pkg;

  localparam int PKT_ADDR_W = 10;
  localparam int PKT_DATA_W = 8;

  localparam int REQ_WR = 0;
  localparam int REQ_RD = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins outright, and on a tie the
// requester that was not granted last time wins.
module rr_arb2
  import pkt_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11)
      winner = ~last_gnt;
    else if (req[REQ_RD])
      winner = 1'b1;
  end

endmodule

// File: rtl/pkt_mem_arbiter.sv
// Round-robin arbiter and byte-per-cycle burst sequencer for the shared packet memory.
// Define PKT_ARB_ABORT_EN to let the granted requester abort its burst by dropping req.
module pkt_mem_arbiter
  import pkt_mem_pkg::*;
#(
  parameter int ADDR_W = PKT_ADDR_W,
  parameter int DATA_W = PKT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [ADDR_W-1:0] start_addr0,
  input  logic [ADDR_W-1:0] start_addr1,
  input  logic [ADDR_W-1:0] len0,
  input  logic [ADDR_W-1:0] len1,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        gnt,
  output logic              beat,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [1:0]        done,
`ifdef PKT_ARB_ABORT_EN
  output logic              aborted,
`endif
  output logic              busy
);

  arb_state_t        state;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] len_q;
  logic              last_gnt;
  logic              win_valid;
  logic              win;

  rr_arb2 u_rr_arb2 (
    .req      (req),
    .last_gnt (last_gnt),
    .valid    (win_valid),
    .winner   (win)
  );

  assign mem_wdata = gnt[REQ_WR] ? wr_data : '0;
  assign rd_data   = mem_rdata;

  // count tracks beats already issued; the beat where count == len_q is the last one
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      beat     <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      rd_valid <= 1'b0;
      done     <= '0;
      busy     <= 1'b0;
      count    <= '0;
      len_q    <= '0;
      last_gnt <= 1'b1;
`ifdef PKT_ARB_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
      rd_valid <= beat & gnt[REQ_RD];
      case (state)
        IDLE: begin
          done <= '0;
          if (win_valid) begin
            state    <= BURST;
            gnt      <= onehot2(win);
            beat     <= 1'b1;
            mem_addr <= win ? start_addr1 : start_addr0;
            len_q    <= win ? len1 : len0;
            count    <= '0;
            mem_we   <= ~win;
            last_gnt <= win;
            busy     <= 1'b1;
          end
        end
        BURST: begin
          if (count == len_q) begin
            state  <= DRAIN;
            beat   <= 1'b0;
            mem_we <= 1'b0;
            done   <= gnt;
          end
`ifdef PKT_ARB_ABORT_EN
          else if ((req & gnt) == 2'b00) begin
            state   <= DRAIN;
            beat    <= 1'b0;
            mem_we  <= 1'b0;
            done    <= gnt;
            aborted <= 1'b1;
          end
`endif
          else begin
            mem_addr <= mem_addr + ADDR_W'(1);
            count    <= count + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state <= IDLE;
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
`ifdef PKT_ARB_ABORT_EN
          aborted <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pkt_mem_arbiter.md
Name: pkt_mem_arbiter

Overview:
- Two-requester arbiter and burst sequencer for the shared 1024-byte packet memory used by the PIT.
- Requester 0 is the write path (incoming packet store); requester 1 is the read path (outgoing packet fetch).
- Grants round-robin, latches start address and length, and drives the memory address, write-enable and data one byte per cycle.
- Pulses a per-requester done at the end of each burst.

Parameters:
- ADDR_W, 10, packet memory address width (depth 2**ADDR_W).
- DATA_W, 8, memory byte width.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  request per requester; held high until matching done.
- start_addr0  in  ADDR_W  burst start address, requester 0.
- start_addr1  in  ADDR_W  burst start address, requester 1.
- len0  in  ADDR_W  burst length minus one, requester 0 (0 = 1 byte, 1023 = 1024 bytes).
- len1  in  ADDR_W  burst length minus one, requester 1.
- wr_data  in  DATA_W  write byte from requester 0; consumed on beat.
- mem_rdata  in  DATA_W  memory read data, 1-cycle synchronous read.
- gnt  out  2  one-hot grant, registered.
- beat  out  1  a memory access occurs this cycle.
- mem_addr  out  ADDR_W  memory address, registered.
- mem_we  out  1  memory write enable, registered.
- mem_wdata  out  DATA_W  wr_data when gnt[0], else 0 (combinational).
- rd_data  out  DATA_W  mem_rdata passthrough.
- rd_valid  out  1  rd_data valid for requester 1.
- done  out  2  one-cycle completion pulse per requester.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, asserted) sets these outputs and registers to 0:
  - outputs: gnt, beat, mem_addr, mem_we, rd_valid, done, busy.
  - internal: count.
  - state = IDLE; last_gnt = 1, so requester 0 wins the first tie.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - If req != 0, pick the winner. Single request wins. Both requesting: the requester != last_gnt wins.
  - Next cycle: gnt = onehot(winner), state = BURST, beat = 1, mem_addr = winner's start_addr, count = 0, len latched, mem_we = (winner==0), last_gnt = winner.
  - Latency: req rise at edge t gives first beat in cycle t+1.
- BURST:
  - Each cycle beat = 1; mem_addr increments modulo 2**ADDR_W (1023 -> 0 wraps silently); count increments.
  - When count == latched len: this is the last beat. Next cycle state = DRAIN, beat = 0, mem_we = 0.
  - Exactly len+1 beats per burst.
- Writer handshake: requester 0 presents byte k on wr_data during the cycle of its k-th beat; the byte is written at the end of that cycle.
- Reader: rd_valid = registered (beat & gnt[1]), i.e. byte k is valid in the cycle after beat k.
- DRAIN:
  - done[winner] = 1 for this cycle only; gnt still held. rd_valid carries the final read byte.
  - Next cycle: gnt = 0, state = IDLE.
- Requester must drop req on seeing done. A req still high in IDLE is a new request. IDLE always lasts at least 1 cycle between bursts.
- start_addr, len and req changes during BURST/DRAIN are ignored; the burst always completes (unless the optional feature is enabled).
- Reset mid-burst: immediate return to reset values; no done pulse; the partially written memory is not restored.
- done and gnt are never asserted for both requesters at once.

Optional Feature:
- Macro: PKT_ARB_ABORT_EN.
- Defined:
  - req[winner] falling during BURST aborts the burst. The cycle after the drop is seen, beat = 0 and mem_we = 0, and state goes to DRAIN.
  - done pulses as normal. Output aborted (1 bit, registered) is 1 alongside done, else 0.
  - Round-robin pointer is still updated.
- Undefined: no aborted port; req drops mid-burst are ignored, per Behaviour.

Decomposition:
- Shared package pkt_mem_pkg:
  - ADDR_W and DATA_W defaults.
  - Requester index constants REQ_WR = 0, REQ_RD = 1.
  - State enum arb_state_t {IDLE, BURST, DRAIN}.
- One natural sub-module: rr_arb2, the combinational 2-way round-robin pick from req and last_gnt. Sequencing stays in the top.

Test Plan:
- Write burst: req=01, start_addr0=0x010, len0=3, wr_data A0..A3 -> gnt=01 one cycle later; 4 beats, mem_we=1, mem_addr 0x010..0x013; done[0] pulses 1 cycle after the last beat.
- Read burst: memory preloaded 0x100..0x104 = 5 bytes, req=10, len1=4 -> rd_valid high 5 consecutive cycles, starting 1 cycle after the first beat; bytes in order; mem_we never 1.
- Contention: req=11 held continuously, len0=len1=1 -> grant order 0,1,0,1; every burst 2 beats; at least 1 IDLE cycle between bursts.
- Wrap: start_addr0=0x3FE, len0=3 -> mem_addr 0x3FE, 0x3FF, 0x000, 0x001; done after 4 beats.
- Reset on beat 2 of a len=7 burst -> same cycle: gnt=0, beat=0, mem_we=0, busy=0; no done; a new req after reset starts at start_addr with a fresh count.
- PKT_ARB_ABORT_EN defined: len0=9, req[0] dropped after beat 3 -> exactly 4 writes, then done[0]=1 with aborted=1 for 1 cycle, then IDLE.
